// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : merges RV32I fetch and load/store ports onto one memory port
// Revision    : 1.0
// ============================================================================
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_read,
   input  logic [31:0] instr_mem_address,
   output logic [31:0] instr_mem_rdata,
   output logic        instr_mem_resp,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_mem_address,
   input  logic [31:0] data_mem_wdata,
   input  logic [3:0]  data_mbe,
   output logic [31:0] data_mem_rdata,
   output logic        data_mem_resp,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_mbe,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_I_BUSY = 3'd1;
   localparam logic [2:0] S_D_BUSY = 3'd2;
   localparam logic [2:0] S_I_RESP = 3'd3;
   localparam logic [2:0] S_D_RESP = 3'd4;

   localparam logic GRANT_INSTR = 1'b0;
   localparam logic GRANT_DATA  = 1'b1;

   logic [2:0]  state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        tag_write_q, tag_write_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_mbe_q, mem_mbe_d;
   logic [31:0] instr_buf_q, instr_buf_d;
   logic [31:0] data_buf_q, data_buf_d;

   logic        data_req;
   logic        instr_match;
   logic        data_match;
   logic        busy_done;

   assign data_req  = data_read | data_write;
   assign busy_done = mem_resp & ((state_q == S_I_BUSY) | (state_q == S_D_BUSY));

   // The mem_* tag doubles as the reference the client must still present in RESP.
   assign instr_match = instr_read & (instr_mem_address == mem_address_q);
   assign data_match  = (data_mem_address == mem_address_q) &
                        (tag_write_q ? (data_write &
                                        (data_mem_wdata == mem_wdata_q) &
                                        (data_mbe == mem_mbe_q))
                                     : data_read);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         last_grant_q  <= GRANT_INSTR;
         tag_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= 32'h0;
         mem_wdata_q   <= 32'h0;
         mem_mbe_q     <= 4'h0;
         instr_buf_q   <= 32'h0;
         data_buf_q    <= 32'h0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         tag_write_q   <= tag_write_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_mbe_q     <= mem_mbe_d;
         instr_buf_q   <= instr_buf_d;
         data_buf_q    <= data_buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (data_req && (!instr_read || (last_grant_q == GRANT_INSTR))) begin
               state_d = S_D_BUSY;
            end else if (instr_read) begin
               state_d = S_I_BUSY;
            end
         end
         S_I_BUSY: begin
            if (mem_resp) begin
               state_d = S_I_RESP;
            end
         end
         S_D_BUSY: begin
            if (mem_resp) begin
               state_d = S_D_RESP;
            end
         end
         S_I_RESP: state_d = S_IDLE;
         S_D_RESP: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      last_grant_d  = last_grant_q;
      tag_write_d   = tag_write_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      mem_mbe_d     = mem_mbe_q;
      instr_buf_d   = instr_buf_q;
      data_buf_d    = data_buf_q;

      if (state_q == S_IDLE) begin
         if (state_d == S_D_BUSY) begin
            tag_write_d   = data_write;
            mem_read_d    = data_read;
            mem_write_d   = data_write;
            mem_address_d = data_mem_address;
            mem_wdata_d   = data_mem_wdata;
            mem_mbe_d     = data_mbe;
         end else if (state_d == S_I_BUSY) begin
            tag_write_d   = 1'b0;
            mem_read_d    = 1'b1;
            mem_write_d   = 1'b0;
            mem_address_d = instr_mem_address;
            mem_wdata_d   = 32'h0;
            mem_mbe_d     = 4'hF;
         end
      end

      // Address/wdata/mbe stay latched past completion for the RESP-cycle compare.
      if (busy_done) begin
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         if (state_q == S_D_BUSY) begin
            last_grant_d = GRANT_DATA;
            data_buf_d   = mem_rdata;
         end else begin
            last_grant_d = GRANT_INSTR;
            instr_buf_d  = mem_rdata;
         end
      end
   end

   always_comb begin
      instr_mem_resp = 1'b0;
      data_mem_resp  = 1'b0;
      if (state_q == S_I_RESP) begin
         instr_mem_resp = instr_match;
      end
      if (state_q == S_D_RESP) begin
         data_mem_resp = data_match;
      end
   end

   assign instr_mem_rdata = instr_buf_q;
   assign data_mem_rdata  = data_buf_q;
   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_address     = mem_address_q;
   assign mem_wdata       = mem_wdata_q;
   assign mem_mbe         = mem_mbe_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// word-level memory model with configurable response latency.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        instr_read;
   logic [31:0] instr_mem_address;
   logic [31:0] instr_mem_rdata;
   logic        instr_mem_resp;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_mem_address;
   logic [31:0] data_mem_wdata;
   logic [3:0]  data_mbe;
   logic [31:0] data_mem_rdata;
   logic        data_mem_resp;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mbe;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   int checks = 0;
   int errors = 0;

   bit auto_en   = 1'b0;
   bit rand_lat  = 1'b0;
   bit stray_req = 1'b0;
   int lat       = 0;

   logic [31:0] mem_array [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];

   logic [31:0] iq    [20];
   logic [31:0] dq_a  [20];
   logic [31:0] dq_w  [20];
   logic [3:0]  dq_be [20];
   bit          dq_st [20];
   logic [31:0] dexp  [20];
   bit          i_done;
   bit          d_done;

   mem_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .instr_read        (instr_read),
      .instr_mem_address (instr_mem_address),
      .instr_mem_rdata   (instr_mem_rdata),
      .instr_mem_resp    (instr_mem_resp),
      .data_read         (data_read),
      .data_write        (data_write),
      .data_mem_address  (data_mem_address),
      .data_mem_wdata    (data_mem_wdata),
      .data_mbe          (data_mbe),
      .data_mem_rdata    (data_mem_rdata),
      .data_mem_resp     (data_mem_resp),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_address       (mem_address),
      .mem_wdata         (mem_wdata),
      .mem_mbe           (mem_mbe),
      .mem_rdata         (mem_rdata),
      .mem_resp          (mem_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_array.exists(a)) return mem_array[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   // Memory side: answers lat+1 cycles after the request first appears.
   initial begin : responder
      int cnt;
      int cur_lat;
      bit active;
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      cnt       = 0;
      cur_lat   = 0;
      active    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_resp) begin
            mem_resp = 1'b0;
            active   = 1'b0;
         end else if (stray_req) begin
            mem_resp  = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
         end else if (auto_en && (mem_read || mem_write)) begin
            if (!active) begin
               active  = 1'b1;
               cnt     = 0;
               cur_lat = rand_lat ? int'($urandom_range(0, 4)) : lat;
            end
            if (cnt >= cur_lat) begin
               mem_resp = 1'b1;
               if (mem_write) mem_array[mem_address] = merge(mem_rd(mem_address), mem_wdata, mem_mbe);
               else           mem_rdata = mem_rd(mem_address);
            end else begin
               cnt++;
            end
         end else begin
            active = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({mem_read, mem_write, mem_mbe} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got rd=%b wr=%b mbe=%h, expected all 0", mem_read, mem_write, mem_mbe);
      end
      checks++;
      if ({mem_address, mem_wdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_addr: got addr=%h wdata=%h, expected 0", mem_address, mem_wdata);
      end
      checks++;
      if ({instr_mem_resp, data_mem_resp, instr_mem_rdata, data_mem_rdata} !== 66'h0) begin
         errors++;
         $display("FAIL reset_client: got iresp=%b dresp=%b irdata=%h drdata=%h, expected 0",
                  instr_mem_resp, data_mem_resp, instr_mem_rdata, data_mem_rdata);
      end
      rst = 1'b1;
      @(negedge clk);
      stray_req = 1'b1;
      @(negedge clk);
      stray_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({instr_mem_resp, data_mem_resp, mem_read, mem_write} !== 4'b0 ||
             {instr_mem_rdata, data_mem_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL idle_stray_resp: cycle %0d iresp=%b dresp=%b rd=%b wr=%b irdata=%h drdata=%h, expected idle zeros",
                     c, instr_mem_resp, data_mem_resp, mem_read, mem_write, instr_mem_rdata, data_mem_rdata);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_fetch();
      bit exp_rd;
      bit exp_rsp;
      auto_en = 1'b1;
      rand_lat = 1'b0;
      lat = 2;
      mem_array[32'h60] = 32'h0050_0093;
      tick();
      instr_read = 1'b1;
      instr_mem_address = 32'h60;
      sample();
      checks++;
      if (mem_read !== 1'b0 || instr_mem_resp !== 1'b0) begin
         errors++;
         $display("FAIL fetch_cycle0: rd=%b iresp=%b, expected 0 0", mem_read, instr_mem_resp);
      end
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 5) instr_read = 1'b0;
         sample();
         exp_rd  = (c <= 3);
         exp_rsp = (c == 4);
         checks++;
         if (mem_read !== exp_rd || mem_write !== 1'b0 || instr_mem_resp !== exp_rsp) begin
            errors++;
            $display("FAIL fetch_timing: cycle %0d rd=%b wr=%b iresp=%b, expected %b 0 %b",
                     c, mem_read, mem_write, instr_mem_resp, exp_rd, exp_rsp);
         end
         if (exp_rd) begin
            checks++;
            if (mem_address !== 32'h60 || mem_mbe !== 4'hF) begin
               errors++;
               $display("FAIL fetch_addr: cycle %0d addr=%h mbe=%h, expected 00000060 f", c, mem_address, mem_mbe);
            end
         end
         if (exp_rsp) begin
            checks++;
            if (instr_mem_rdata !== 32'h0050_0093) begin
               errors++;
               $display("FAIL fetch_rdata: got %h expected 00500093", instr_mem_rdata);
            end
         end
      end
   endtask

   task automatic test_store();
      bit exp_wr;
      bit exp_rsp;
      lat = 1;
      ref_mem[32'h2000] = merge(ref_rd(32'h2000), 32'h0000_AB00, 4'b0010);
      tick();
      data_write = 1'b1;
      data_mem_address = 32'h2000;
      data_mem_wdata = 32'h0000_AB00;
      data_mbe = 4'b0010;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) data_write = 1'b0;
         sample();
         exp_wr  = (c <= 2);
         exp_rsp = (c == 3);
         checks++;
         if (mem_write !== exp_wr || mem_read !== 1'b0 || data_mem_resp !== exp_rsp || instr_mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL store_timing: cycle %0d wr=%b rd=%b dresp=%b iresp=%b, expected %b 0 %b 0",
                     c, mem_write, mem_read, data_mem_resp, instr_mem_resp, exp_wr, exp_rsp);
         end
         if (exp_wr) begin
            checks++;
            if (mem_address !== 32'h2000 || mem_wdata !== 32'h0000_AB00 || mem_mbe !== 4'b0010) begin
               errors++;
               $display("FAIL store_fields: cycle %0d addr=%h wdata=%h mbe=%b, expected 00002000 0000ab00 0010",
                        c, mem_address, mem_wdata, mem_mbe);
            end
         end
      end
      checks++;
      if (mem_rd(32'h2000) !== ((init_word(32'h2000) & 32'hFFFF_00FF) | 32'h0000_AB00)) begin
         errors++;
         $display("FAIL store_memory: got %h expected %h", mem_rd(32'h2000),
                  (init_word(32'h2000) & 32'hFFFF_00FF) | 32'h0000_AB00);
      end
   endtask

   task automatic test_flush();
      bit exp_rd;
      bit exp_rsp;
      logic [31:0] exp_a;
      lat = 2;
      tick();
      instr_read = 1'b1;
      instr_mem_address = 32'h80;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 2)  instr_mem_address = 32'h200;
         if (c == 10) instr_read = 1'b0;
         sample();
         exp_rd  = (c <= 3) || (c >= 6 && c <= 8);
         exp_rsp = (c == 9);
         exp_a   = (c <= 3) ? 32'h80 : 32'h200;
         checks++;
         if (mem_read !== exp_rd || instr_mem_resp !== exp_rsp) begin
            errors++;
            $display("FAIL flush_timing: cycle %0d rd=%b iresp=%b, expected %b %b", c, mem_read, instr_mem_resp, exp_rd, exp_rsp);
         end
         if (exp_rd) begin
            checks++;
            if (mem_address !== exp_a) begin
               errors++;
               $display("FAIL flush_addr: cycle %0d addr=%h expected %h", c, mem_address, exp_a);
            end
         end
         if (exp_rsp) begin
            checks++;
            if (instr_mem_rdata !== ref_rd(32'h200)) begin
               errors++;
               $display("FAIL flush_rdata: got %h expected %h", instr_mem_rdata, ref_rd(32'h200));
            end
         end
      end
   endtask

   task automatic test_latency_random();
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [3:0]  be;
      bit          st;
      bit          busy;
      rand_lat = 1'b0;
      for (int n = 0; n < 8; n++) begin
         st  = ($urandom_range(0, 1) == 1);
         a   = 32'h3000 + (32'($urandom_range(0, 7)) << 2);
         wd  = $urandom();
         be  = 4'($urandom_range(1, 15));
         lat = int'($urandom_range(0, 5));
         exp_rd = ref_rd(a);
         if (st) ref_mem[a] = merge(ref_rd(a), wd, be);
         tick();
         data_read = !st;
         data_write = st;
         data_mem_address = a;
         data_mem_wdata = wd;
         data_mbe = be;
         for (int c = 1; c <= lat + 3; c++) begin
            tick();
            if (c == lat + 3) begin
               data_read = 1'b0;
               data_write = 1'b0;
            end
            sample();
            busy = (c <= lat + 1);
            checks++;
            if (mem_read !== (busy && !st) || mem_write !== (busy && st) || data_mem_resp !== (c == lat + 2)) begin
               errors++;
               $display("FAIL latency_timing: txn %0d lat %0d cycle %0d rd=%b wr=%b dresp=%b",
                        n, lat, c, mem_read, mem_write, data_mem_resp);
            end
            if (busy) begin
               checks++;
               if (mem_address !== a || (st && (mem_wdata !== wd || mem_mbe !== be))) begin
                  errors++;
                  $display("FAIL latency_fields: txn %0d addr=%h wdata=%h mbe=%h, expected %h %h %h",
                           n, mem_address, mem_wdata, mem_mbe, a, wd, be);
               end
            end
            if (c == lat + 2 && !st) begin
               checks++;
               if (data_mem_rdata !== exp_rd) begin
                  errors++;
                  $display("FAIL latency_rdata: txn %0d got %h expected %h", n, data_mem_rdata, exp_rd);
               end
            end
         end
      end
   endtask

   task automatic test_tie_after_reset();
      int ni;
      int nd;
      int ntx;
      logic [31:0] tx0;
      logic [31:0] tx1;
      bit prev_busy;
      bit drop_i;
      bit drop_d;
      ni = 0; nd = 0; ntx = 0; tx0 = 32'h0; tx1 = 32'h0;
      prev_busy = 1'b0; drop_i = 1'b0; drop_d = 1'b0;
      lat = 0;
      rand_lat = 1'b0;
      do_reset();
      tick();
      instr_read = 1'b1;
      instr_mem_address = 32'h64;
      data_read = 1'b1;
      data_mem_address = 32'h1000;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) tick();
         if (drop_i) instr_read = 1'b0;
         if (drop_d) data_read = 1'b0;
         sample();
         if ((mem_read || mem_write) && !prev_busy) begin
            if (ntx == 0) tx0 = mem_address;
            if (ntx == 1) tx1 = mem_address;
            ntx++;
         end
         prev_busy = mem_read || mem_write;
         if (instr_mem_resp) begin
            ni++;
            drop_i = 1'b1;
            checks++;
            if (instr_mem_rdata !== ref_rd(32'h64)) begin
               errors++;
               $display("FAIL tie_irdata: got %h expected %h", instr_mem_rdata, ref_rd(32'h64));
            end
         end
         if (data_mem_resp) begin
            nd++;
            drop_d = 1'b1;
            checks++;
            if (data_mem_rdata !== ref_rd(32'h1000)) begin
               errors++;
               $display("FAIL tie_drdata: got %h expected %h", data_mem_rdata, ref_rd(32'h1000));
            end
         end
      end
      checks++;
      if (ntx != 2 || tx0 !== 32'h1000 || tx1 !== 32'h64) begin
         errors++;
         $display("FAIL tie_order: %0d txns first=%h second=%h, expected 2 00001000 00000064", ntx, tx0, tx1);
      end
      checks++;
      if (ni != 1 || nd != 1) begin
         errors++;
         $display("FAIL tie_resp_count: instr=%0d data=%0d, expected 1 1", ni, nd);
      end
   endtask

   task automatic test_contention();
      for (int i = 0; i < 20; i++) begin
         iq[i]    = 32'($urandom_range(0, 1023)) << 2;
         dq_a[i]  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
         dq_w[i]  = $urandom();
         dq_be[i] = 4'($urandom_range(1, 15));
         dq_st[i] = ($urandom_range(0, 1) == 1);
         dexp[i]  = ref_rd(dq_a[i]);
         if (dq_st[i]) ref_mem[dq_a[i]] = merge(ref_rd(dq_a[i]), dq_w[i], dq_be[i]);
      end
      rand_lat = 1'b1;
      i_done = 1'b0;
      d_done = 1'b0;
      do_reset();
      tick();
      fork
         begin : cli_i
            int w;
            for (int i = 0; i < 20; i++) begin
               instr_read = 1'b1;
               instr_mem_address = iq[i];
               w = 0;
               do begin
                  @(negedge clk);
                  w++;
               end while (instr_mem_resp !== 1'b1 && w < 200);
               checks++;
               if (instr_mem_resp !== 1'b1) begin
                  errors++;
                  $display("FAIL contention_itimeout: fetch %0d got no resp within 200 cycles", i);
                  break;
               end else if (instr_mem_rdata !== ref_rd(iq[i])) begin
                  errors++;
                  $display("FAIL contention_irdata: fetch %0d got %h expected %h", i, instr_mem_rdata, ref_rd(iq[i]));
               end
               @(posedge clk);
               #1;
            end
            instr_read = 1'b0;
            i_done = 1'b1;
         end
         begin : cli_d
            int w;
            for (int i = 0; i < 20; i++) begin
               data_read = !dq_st[i];
               data_write = dq_st[i];
               data_mem_address = dq_a[i];
               data_mem_wdata = dq_w[i];
               data_mbe = dq_be[i];
               w = 0;
               do begin
                  @(negedge clk);
                  w++;
               end while (data_mem_resp !== 1'b1 && w < 200);
               checks++;
               if (data_mem_resp !== 1'b1) begin
                  errors++;
                  $display("FAIL contention_dtimeout: access %0d got no resp within 200 cycles", i);
                  break;
               end else if (!dq_st[i] && data_mem_rdata !== dexp[i]) begin
                  errors++;
                  $display("FAIL contention_drdata: load %0d got %h expected %h", i, data_mem_rdata, dexp[i]);
               end
               @(posedge clk);
               #1;
            end
            data_read = 1'b0;
            data_write = 1'b0;
            d_done = 1'b1;
         end
         begin : monitor
            int ntx;
            int cyc;
            int idx;
            bit busy_prev;
            logic [31:0] a0;
            ntx = 0; cyc = 0; busy_prev = 1'b0; a0 = 32'h0;
            while (!(i_done && d_done) && cyc < 4000) begin
               @(negedge clk);
               cyc++;
               checks++;
               if (mem_read && mem_write) begin
                  errors++;
                  $display("FAIL contention_rw_both: cycle %0d read and write both high", cyc);
               end
               if ((mem_read || mem_write) && !busy_prev) begin
                  idx = ntx / 2;
                  checks++;
                  if (ntx >= 40) begin
                     errors++;
                     $display("FAIL contention_extra_txn: txn %0d addr=%h beyond 40", ntx, mem_address);
                  end else if (ntx % 2 == 0) begin
                     if ({mem_read, mem_write, mem_address} !== {!dq_st[idx], dq_st[idx], dq_a[idx]} ||
                         (dq_st[idx] && (mem_wdata !== dq_w[idx] || mem_mbe !== dq_be[idx]))) begin
                        errors++;
                        $display("FAIL contention_dgrant: txn %0d rd=%b wr=%b addr=%h wdata=%h mbe=%h, expected data %0d rd=%b addr=%h wdata=%h mbe=%h",
                                 ntx, mem_read, mem_write, mem_address, mem_wdata, mem_mbe,
                                 idx, !dq_st[idx], dq_a[idx], dq_w[idx], dq_be[idx]);
                     end
                  end else begin
                     if ({mem_read, mem_write, mem_address, mem_mbe} !== {1'b1, 1'b0, iq[idx], 4'hF}) begin
                        errors++;
                        $display("FAIL contention_igrant: txn %0d rd=%b wr=%b addr=%h mbe=%h, expected fetch %0d addr=%h",
                                 ntx, mem_read, mem_write, mem_address, mem_mbe, idx, iq[idx]);
                     end
                  end
                  a0 = mem_address;
                  ntx++;
               end else if (mem_read || mem_write) begin
                  checks++;
                  if (mem_address !== a0) begin
                     errors++;
                     $display("FAIL contention_stable: addr changed %h -> %h mid-transaction", a0, mem_address);
                  end
               end
               busy_prev = mem_read || mem_write;
            end
            checks++;
            if (ntx != 40) begin
               errors++;
               $display("FAIL contention_txn_count: got %0d expected 40", ntx);
            end
         end
      join
      rand_lat = 1'b0;
   endtask

   task automatic test_async_reset();
      lat = 10;
      tick();
      data_write = 1'b1;
      data_mem_address = 32'h2040;
      data_mem_wdata = 32'hCAFE_F00D;
      data_mbe = 4'hF;
      tick();
      tick();
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_address !== 32'h2040) begin
         errors++;
         $display("FAIL async_pre_busy: wr=%b addr=%h, expected 1 00002040", mem_write, mem_address);
      end
      #1;
      rst = 1'b0;
      data_write = 1'b0;
      #1;
      checks++;
      if ({mem_read, mem_write, mem_address, mem_wdata, mem_mbe} !== 70'h0 ||
          {instr_mem_resp, data_mem_resp, instr_mem_rdata, data_mem_rdata} !== 66'h0) begin
         errors++;
         $display("FAIL async_reset_outputs: rd=%b wr=%b addr=%h wdata=%h mbe=%h iresp=%b dresp=%b, expected zeros",
                  mem_read, mem_write, mem_address, mem_wdata, mem_mbe, instr_mem_resp, data_mem_resp);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      stray_req = 1'b1;
      @(negedge clk);
      stray_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({instr_mem_resp, data_mem_resp, mem_read, mem_write} !== 4'b0 || data_mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_late_resp: cycle %0d iresp=%b dresp=%b rd=%b wr=%b drdata=%h, expected zeros",
                     c, instr_mem_resp, data_mem_resp, mem_read, mem_write, data_mem_rdata);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b0;
      instr_read = 1'b0;
      instr_mem_address = 32'h0;
      data_read = 1'b0;
      data_write = 1'b0;
      data_mem_address = 32'h0;
      data_mem_wdata = 32'h0;
      data_mbe = 4'h0;
      test_reset();
      test_single_fetch();
      test_store();
      test_flush();
      test_latency_random();
      test_tie_after_reset();
      test_contention();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
